fpsu_alt_arb: RTL



---
 rtl/fpsu_pkg.sv | 17 +
 rtl/fpsu_alt_arb_rr_pick.sv | 28 ++
 rtl/fpsu_alt_arb.sv | 102 ++++++++++
 3 files changed

// File: rtl/fpsu_pkg.sv
// Shared definitions for the lane-2 FP store/shuffle path and its side-port arbiter.
package fpsu_pkg;
    typedef enum logic [1:0] {
        ALT_NONE = 2'b00,
        ALT_A    = 2'b01,
        ALT_B    = 2'b10,
        ALT_AB   = 2'b11
    } alt_mode_e;

    localparam int ALT_LAT = 4;
    localparam int ALT_DW  = 68;

    typedef struct packed {
        logic       v;
        logic [1:0] id;
    } alt_tag_t;
endpackage

// File: rtl/fpsu_alt_arb_rr_pick.sv
// Round-robin one-hot picker: first set bit of req searching upward from ptr, wrapping.
module rr_pick #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          found
);
    logic [PW-1:0] j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end
endmodule

// File: rtl/fpsu_alt_arb.sv
// Lane-2 alternate-input side-port arbiter: round-robin grant, registered issue,
// tag delay line for result steering, and a starvation hold towards the scheduler.
module fpsu_alt_arb
    import fpsu_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int LAT    = ALT_LAT,
    parameter int STARVE = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_vld,
    input  logic [NREQ-1:0][1:0]          req_mode,
    input  logic [NREQ-1:0][ALT_DW-1:0]   req_data0,
    input  logic [NREQ-1:0][ALT_DW-1:0]   req_data1,
    output logic [NREQ-1:0]               req_rdy,
    input  logic                          lane_busy,
    input  logic                          flush,
    output logic [1:0]                    ALT_INP,
    output logic [ALT_DW-1:0]             ALTDATA0,
    output logic [ALT_DW-1:0]             ALTDATA1,
    input  logic [ALT_DW-1:0]             XI_dataS,
    output logic [NREQ-1:0]               res_vld,
    output logic [ALT_DW-1:0]             res_data,
    output logic                          lane_hold
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(STARVE + 1);

    logic [NREQ-1:0] eligible;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   g;
    logic            grant_any;
    logic [CW-1:0]   starve_cnt;
    logic [CW-1:0]   starve_nxt;
    alt_tag_t        tag_pipe [0:LAT];

    // Reset is folded into eligibility so nothing is granted in a reset cycle.
    assign eligible = req_vld & {NREQ{~lane_busy & ~flush & rst}};

    rr_pick #(.N(NREQ)) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .gnt   (req_rdy),
        .idx   (g),
        .found (grant_any)
    );

    // Payload registers hold their last value when idle to avoid toggling the lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ALT_INP  <= ALT_NONE;
            ALTDATA0 <= '0;
            ALTDATA1 <= '0;
            rr_ptr   <= '0;
        end else if (grant_any) begin
            ALT_INP  <= req_mode[g];
            ALTDATA0 <= req_data0[g];
            ALTDATA1 <= req_data1[g];
            rr_ptr   <= (int'(g) == NREQ - 1) ? '0 : g + PW'(1);
        end else begin
            ALT_INP  <= ALT_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int s = 0; s <= LAT; s++) tag_pipe[s] <= '0;
        end else begin
            tag_pipe[0] <= '{v: grant_any, id: 2'(g)};
            for (int s = 1; s <= LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    // Last stage lines up with XI_dataS, so the steering is purely combinational.
    always_comb begin
        res_vld  = '0;
        res_data = '0;
        if (tag_pipe[LAT].v) begin
            res_vld[PW'(tag_pipe[LAT].id)] = 1'b1;
            res_data                       = XI_dataS;
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (grant_any || flush || req_vld == '0)
            starve_nxt = '0;
        else if (lane_busy && starve_cnt != CW'(STARVE))
            starve_nxt = starve_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
            lane_hold  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            lane_hold  <= (starve_nxt == CW'(STARVE));
        end
    end
endmodule
